// File: rtl/bmp_frame_buf_pkg.sv
// bmp_frame_buf_pkg: shared state encoding and default geometry for the bitmap frame path.
package bmp_frame_buf_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FULL, SWEEP} state_t;
  localparam int BMP_ROW_W  = 24;
  localparam int BMP_ROWS   = 64;
  localparam int BMP_IDX_W  = 6;
  localparam int BMP_CIDX_W = 5;
endpackage

// File: rtl/bmp_col_select.sv
// bmp_col_select: picks bit col_idx of every stored row to form one ROWS-bit column word.
module bmp_col_select #(
  parameter int ROW_W  = 24,
  parameter int ROWS   = 64,
  parameter int CIDX_W = 5
) (
  input  logic [ROW_W*ROWS-1:0] frame,
  input  logic [CIDX_W-1:0]     col_idx,
  output logic [ROWS-1:0]       col_out
);
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [ROW_W-1:0] row;
    assign row = frame[r*ROW_W +: ROW_W];
    assign col_out[r] = row[col_idx];
  end
endmodule

// File: rtl/bmp_frame_buf.sv
// bmp_frame_buf: ROWS x ROW_W bitmap store with serial/parallel load, row reads
// and a handshaked column sweep.
import bmp_frame_buf_pkg::*;

module bmp_frame_buf #(
  parameter int ROW_W  = BMP_ROW_W,
  parameter int ROWS   = BMP_ROWS,
  parameter int IDX_W  = BMP_IDX_W,
  parameter int CIDX_W = BMP_CIDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  row_valid,
  input  logic [ROW_W-1:0]      row_data,
  output logic                  row_ready,
  input  logic                  load_par,
  input  logic [ROW_W*ROWS-1:0] frame_in,
  output logic                  frame_full,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_row_idx,
  output logic [ROW_W-1:0]      row_out,
  output logic                  row_out_valid,
  input  logic                  col_start,
  output logic [ROWS-1:0]       col_out,
  output logic [CIDX_W-1:0]     col_idx,
  output logic                  col_valid,
  output logic                  col_last,
  input  logic                  col_ready
);
  localparam int AW = ROWS > 1 ? $clog2(ROWS) : 1;
  state_t state;
  logic [IDX_W-1:0] wr_ptr;
  logic [ROW_W-1:0] mem [ROWS];
  logic [ROW_W*ROWS-1:0] flat;
  logic row_acc, par_ld, col_acc, rd_ok;
  assign row_ready  = ~clear & ((state == IDLE & ~load_par) | state == LOAD);
  assign row_acc    = row_valid & row_ready;
  assign par_ld     = ~clear & load_par & (state == IDLE | state == FULL);
  assign col_valid  = state == SWEEP;
  assign col_last   = col_valid && col_idx == CIDX_W'(ROW_W - 1);
  assign col_acc    = col_valid & col_ready;
  assign frame_full = state == FULL || state == SWEEP;
  assign rd_ok      = {1'b0, rd_row_idx} < (IDX_W + 1)'(ROWS);
  for (genvar r = 0; r < ROWS; r++) begin : g_flat
    assign flat[r*ROW_W +: ROW_W] = mem[r];
  end
  bmp_col_select #(.ROW_W(ROW_W), .ROWS(ROWS), .CIDX_W(CIDX_W)) u_sel (
    .frame(flat), .col_idx(col_idx), .col_out(col_out)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int r = 0; r < ROWS; r++) mem[r] <= '0;
    else if (clear) for (int r = 0; r < ROWS; r++) mem[r] <= '0;
    else if (par_ld) for (int r = 0; r < ROWS; r++) mem[r] <= frame_in[r*ROW_W +: ROW_W];
    else if (row_acc) mem[wr_ptr[AW-1:0]] <= row_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      col_idx       <= '0;
      row_out       <= '0;
      row_out_valid <= 1'b0;
    end else begin
      row_out_valid <= rd_en;
      if (rd_en) row_out <= rd_ok ? mem[rd_row_idx[AW-1:0]] : '0;
      if (clear) begin
        state   <= IDLE;
        wr_ptr  <= '0;
        col_idx <= '0;
      end else begin
        case (state)
          IDLE: if (par_ld) state <= FULL;
                else if (row_acc) begin
                  state  <= ROWS == 1 ? FULL : LOAD;
                  wr_ptr <= ROWS == 1 ? '0 : IDX_W'(1);
                end
          LOAD: if (row_acc) begin
                  state  <= wr_ptr == IDX_W'(ROWS - 1) ? FULL : LOAD;
                  wr_ptr <= wr_ptr == IDX_W'(ROWS - 1) ? '0 : wr_ptr + 1'b1;
                end
          FULL: if (col_start) begin
                  state   <= SWEEP;
                  col_idx <= '0;
                end
          SWEEP: if (col_acc) begin
                  state   <= col_last ? FULL : SWEEP;
                  col_idx <= col_last ? '0 : col_idx + 1'b1;
                end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bmp_frame_buf.sv
// tb_bmp_frame_buf: directed scoreboard bench for bmp_frame_buf.
module tb_bmp_frame_buf;
  localparam int ROW_W = 24, ROWS = 64, IDX_W = 7, CIDX_W = 5;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, row_valid = 1'b0, load_par = 1'b0;
  logic rd_en = 1'b0, col_start = 1'b0, col_ready = 1'b0;
  logic [ROW_W-1:0] row_data = '0;
  logic [ROW_W*ROWS-1:0] frame_in = '0;
  logic [IDX_W-1:0] rd_row_idx = '0;
  logic row_ready, frame_full, row_out_valid, col_valid, col_last;
  logic [ROW_W-1:0] row_out;
  logic [ROWS-1:0] col_out;
  logic [CIDX_W-1:0] col_idx;
  typedef struct {logic [4:0] idx; logic [63:0] word;} col_t;
  col_t cq[$];
  logic [23:0] rq[$];
  logic [23:0] mdl [ROWS];
  int n_tests = 0, n_fail = 0;

  bmp_frame_buf #(.ROW_W(ROW_W), .ROWS(ROWS), .IDX_W(IDX_W), .CIDX_W(CIDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .row_valid(row_valid), .row_data(row_data),
    .row_ready(row_ready), .load_par(load_par), .frame_in(frame_in), .frame_full(frame_full),
    .rd_en(rd_en), .rd_row_idx(rd_row_idx), .row_out(row_out), .row_out_valid(row_out_valid),
    .col_start(col_start), .col_out(col_out), .col_idx(col_idx), .col_valid(col_valid),
    .col_last(col_last), .col_ready(col_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int idx, input logic [23:0] exp);
    rd_row_idx = IDX_W'(idx);
    rd_en = 1'b1;
    rq.push_back(exp);
    step();
    rd_en = 1'b0;
    chk("row_out_valid", row_out_valid, 1);
    chk("row_out", row_out, rq.pop_front());
  endtask

  task automatic sweep(input logic [3:0] pat, input int exp_cycles);
    int k, cyc;
    for (int c = 0; c < ROW_W; c++) begin
      col_t e;
      e.idx = 5'(c);
      e.word = '0;
      for (int r = 0; r < ROWS; r++) e.word[r] = mdl[r][c];
      cq.push_back(e);
    end
    col_start = 1'b1;
    step();
    col_start = 1'b0;
    k = 0;
    cyc = 0;
    while (cq.size() > 0 && cyc < 300) begin
      col_ready = pat[k % 4];
      k++;
      chk("col_valid", col_valid, 1);
      chk("col_idx", col_idx, cq[0].idx);
      chk("col_out", col_out, cq[0].word);
      chk("col_last", col_last, cq[0].idx == 5'd23);
      if (col_ready) void'(cq.pop_front());
      step();
      cyc++;
    end
    col_ready = 1'b0;
    chk("sweep_done", cq.size(), 0);
    if (exp_cycles > 0) chk("sweep_cycles", cyc, exp_cycles);
    chk("after_sweep_valid", col_valid, 0);
    chk("after_sweep_full", frame_full, 1);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) mdl[r] = '0;
    #12;
    chk("rst_full", frame_full, 0);
    chk("rst_col_valid", col_valid, 0);
    chk("rst_col_last", col_last, 0);
    chk("rst_col_idx", col_idx, 0);
    chk("rst_row_out", row_out, 0);
    chk("rst_row_out_valid", row_out_valid, 0);
    chk("rst_row_ready", row_ready, 1);
    rst_n = 1'b1;
    step();

    row_valid = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      row_data = 24'(r * 24'h010101);
      mdl[r] = row_data;
      step();
      if (r == 0) chk("load_ready", row_ready, 1);
      if (r == ROWS - 2) chk("full_before_last", frame_full, 0);
      if (r == ROWS - 1) chk("full_after_last", frame_full, 1);
    end
    row_valid = 1'b0;
    chk("full_ready", row_ready, 0);
    rd(5, 24'h050505);
    step();
    chk("row_out_valid_drop", row_out_valid, 0);
    chk("row_out_hold", row_out, 24'h050505);

    for (int r = 0; r < ROWS; r++) begin
      mdl[r] = 24'(1) << (r % 24);
      frame_in[r*ROW_W +: ROW_W] = mdl[r];
    end
    load_par = 1'b1;
    step();
    load_par = 1'b0;
    chk("par_full", frame_full, 1);
    rd(30, 24'h000040);
    sweep(4'b1111, 24);
    sweep(4'b1001, -1);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_full", frame_full, 0);
    for (int r = 0; r < ROWS; r++) begin
      mdl[r] = 24'($urandom);
      frame_in[r*ROW_W +: ROW_W] = mdl[r];
    end
    load_par = 1'b1;
    row_valid = 1'b1;
    row_data = 24'hFFFFFF;
    #1;
    chk("idle_par_ready", row_ready, 0);
    step();
    load_par = 1'b0;
    row_valid = 1'b0;
    chk("idle_par_full", frame_full, 1);
    rd(0, mdl[0]);
    rd(17, mdl[17]);
    rd(63, mdl[63]);

    col_start = 1'b1;
    step();
    col_start = 1'b0;
    col_ready = 1'b1;
    repeat (10) step();
    chk("mid_sweep_idx", col_idx, 10);
    clear = 1'b1;
    step();
    clear = 1'b0;
    col_ready = 1'b0;
    chk("clr_col_valid", col_valid, 0);
    chk("clr_full", frame_full, 0);
    chk("clr_col_idx", col_idx, 0);
    for (int r = 0; r < ROWS; r++) mdl[r] = '0;
    rd(3, 24'h0);

    row_valid = 1'b1;
    for (int r = 0; r < 30; r++) begin
      row_data = 24'(r * 24'h010101);
      step();
    end
    row_valid = 1'b0;
    rd(2, 24'h020202);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_row_out", row_out, 0);
    chk("arst_full", frame_full, 0);
    chk("arst_col_valid", col_valid, 0);
    step();
    rst_n = 1'b1;
    rd(3, 24'h0);
    row_valid = 1'b1;
    row_data = 24'hABCDEF;
    step();
    row_valid = 1'b0;
    chk("one_row_full", frame_full, 0);
    chk("load_ready2", row_ready, 1);
    col_start = 1'b1;
    step();
    col_start = 1'b0;
    chk("load_col_start", col_valid, 0);
    rd(64, 24'h0);
    rd(0, 24'hABCDEF);
    clear = 1'b1;
    step();
    clear = 1'b0;
    col_start = 1'b1;
    step();
    col_start = 1'b0;
    chk("idle_col_start", col_valid, 0);
    chk("idle_full", frame_full, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
